// File: rtl/ux607_gnrl_icb2wishb_split.sv
// ICB-to-Wishbone master bridge: one wide ICB transfer becomes one or more narrow
// Wishbone classic beats, with read data merged back into the ICB byte lanes.
module ux607_gnrl_icb2wishb_split #(
    parameter int AW      = 32,
    parameter int ICB_DW  = 32,
    parameter int WB_DW   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_icb_cmd_valid,
    output logic                i_icb_cmd_ready,
    input  logic                i_icb_cmd_read,
    input  logic [AW-1:0]       i_icb_cmd_addr,
    input  logic [ICB_DW-1:0]   i_icb_cmd_wdata,
    input  logic [ICB_DW/8-1:0] i_icb_cmd_wmask,
    input  logic [1:0]          i_icb_cmd_size,
    output logic                i_icb_rsp_valid,
    input  logic                i_icb_rsp_ready,
    output logic                i_icb_rsp_err,
    output logic [ICB_DW-1:0]   i_icb_rsp_rdata,
    output logic [AW-1:0]       wb_adr,
    output logic [WB_DW-1:0]    wb_dat_w,
    output logic [WB_DW/8-1:0]  wb_sel,
    output logic                wb_we,
    output logic                wb_stb,
    output logic                wb_cyc,
    input  logic [WB_DW-1:0]    wb_dat_r,
    input  logic                wb_ack,
    input  logic                wb_err
);

    localparam int NB       = ICB_DW / WB_DW;
    localparam int SW       = WB_DW / 8;
    localparam int MW       = ICB_DW / 8;
    localparam int OFFW     = $clog2(MW);
    localparam int SELW     = $clog2(SW);
    localparam int LW       = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
    localparam int TMO_LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [1:0]       state;
    logic [AW-1:OFFW] addr_hi;
    logic             read_q;
    logic [ICB_DW-1:0] wdata_q;
    logic [MW-1:0]    mask_q;
    logic [LW-1:0]    lane_q;
    logic [TW-1:0]    tmo_cnt;

    logic [15:0]   rd_ones;
    logic [15:0]   rd_mask_wide;
    logic [MW-1:0] cmd_mask;
    logic [LW:0]   first_lane;
    logic [LW:0]   next_lane;

    function automatic logic [NB-1:0] lanes_of(input logic [MW-1:0] m);
        for (int k = 0; k < NB; k++) lanes_of[k] = |m[k*SW +: SW];
    endfunction

    // Lowest active lane at or above 'from'; MSB of the result flags a hit.
    function automatic logic [LW:0] first_from(input logic [NB-1:0] act, input int from);
        first_from = '0;
        for (int k = NB - 1; k >= 0; k--)
            if (act[k] && k >= from) first_from = {1'b1, LW'(k)};
    endfunction

    function automatic logic [AW-1:0] beat_adr(input logic [AW-1:OFFW] hi, input logic [LW-1:0] k);
        beat_adr = {hi, OFFW'(0)} | (AW'(k) << SELW);
    endfunction

    function automatic logic [SW-1:0] lane_sel(input logic [MW-1:0] m, input int k);
        lane_sel = m[k*SW +: SW];
    endfunction

    function automatic logic [WB_DW-1:0] lane_dat(input logic [ICB_DW-1:0] d, input int k);
        lane_dat = d[k*WB_DW +: WB_DW];
    endfunction

    assign i_icb_cmd_ready = (state == S_IDLE);

    always_comb begin
        rd_ones      = (16'd1 << (5'd1 << i_icb_cmd_size)) - 16'd1;
        rd_mask_wide = rd_ones << i_icb_cmd_addr[OFFW-1:0];
        cmd_mask     = i_icb_cmd_read ? rd_mask_wide[MW-1:0] : i_icb_cmd_wmask;
        first_lane   = first_from(lanes_of(cmd_mask), 0);
        next_lane    = first_from(lanes_of(mask_q), int'(lane_q) + 1);
    end

    // The first beat is launched straight from the command inputs so it appears one cycle after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            addr_hi         <= '0;
            read_q          <= 1'b0;
            wdata_q         <= '0;
            mask_q          <= '0;
            lane_q          <= '0;
            tmo_cnt         <= '0;
            wb_cyc          <= 1'b0;
            wb_stb          <= 1'b0;
            wb_we           <= 1'b0;
            wb_adr          <= '0;
            wb_dat_w        <= '0;
            wb_sel          <= '0;
            i_icb_rsp_valid <= 1'b0;
            i_icb_rsp_err   <= 1'b0;
            i_icb_rsp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_icb_cmd_valid) begin
                        addr_hi         <= i_icb_cmd_addr[AW-1:OFFW];
                        read_q          <= i_icb_cmd_read;
                        wdata_q         <= i_icb_cmd_wdata;
                        mask_q          <= cmd_mask;
                        tmo_cnt         <= '0;
                        i_icb_rsp_rdata <= '0;
                        i_icb_rsp_err   <= 1'b0;
                        if (first_lane[LW]) begin
                            state    <= S_BEAT;
                            lane_q   <= first_lane[LW-1:0];
                            wb_cyc   <= 1'b1;
                            wb_stb   <= 1'b1;
                            wb_we    <= ~i_icb_cmd_read;
                            wb_adr   <= beat_adr(i_icb_cmd_addr[AW-1:OFFW], first_lane[LW-1:0]);
                            wb_sel   <= lane_sel(cmd_mask, int'(first_lane[LW-1:0]));
                            wb_dat_w <= lane_dat(i_icb_cmd_wdata, int'(first_lane[LW-1:0]));
                        end else begin
                            state           <= S_RSP;
                            i_icb_rsp_valid <= 1'b1;
                        end
                    end
                end
                S_BEAT: begin
                    if (wb_err) begin
                        state           <= S_RSP;
                        wb_cyc          <= 1'b0;
                        wb_stb          <= 1'b0;
                        i_icb_rsp_valid <= 1'b1;
                        i_icb_rsp_err   <= 1'b1;
                    end else if (wb_ack) begin
                        if (read_q) i_icb_rsp_rdata[lane_q*WB_DW +: WB_DW] <= wb_dat_r;
                        tmo_cnt <= '0;
                        if (next_lane[LW]) begin
                            lane_q   <= next_lane[LW-1:0];
                            wb_adr   <= beat_adr(addr_hi, next_lane[LW-1:0]);
                            wb_sel   <= lane_sel(mask_q, int'(next_lane[LW-1:0]));
                            wb_dat_w <= lane_dat(wdata_q, int'(next_lane[LW-1:0]));
                        end else begin
                            state           <= S_RSP;
                            wb_cyc          <= 1'b0;
                            wb_stb          <= 1'b0;
                            i_icb_rsp_valid <= 1'b1;
                        end
                    end else if (TMO_CYC != 0 && tmo_cnt == TW'(TMO_LAST)) begin
                        state           <= S_RSP;
                        wb_cyc          <= 1'b0;
                        wb_stb          <= 1'b0;
                        i_icb_rsp_valid <= 1'b1;
                        i_icb_rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_RSP: begin
                    if (i_icb_rsp_ready) begin
                        state           <= S_IDLE;
                        i_icb_rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ux607_gnrl_icb2wishb_split.md
Name: ux607_gnrl_icb2wishb_split

Overview:
- Parametrised ICB-to-Wishbone master bridge. It splits one ICB_DW-wide ICB transfer into 1..ICB_DW/WB_DW narrow Wishbone classic-cycle beats.
- Read data is re-assembled into the correct ICB byte lanes. The ICB response has a proper valid/ready handshake, and slave error plus beat timeout are reported on rsp_err.
- Sits in the subsystem between the peripheral ICB fabric and narrow (8/16-bit) Wishbone peripherals such as UART/I2C/SPI controllers.

Parameters:
- AW, 32, address width.
- ICB_DW, 32, ICB data width; 32 or 64.
- WB_DW, 8, Wishbone data width; 8, 16 or 32, must be ≤ ICB_DW. NB = ICB_DW/WB_DW lanes; SW = WB_DW/8 select bits.
- TMO_CYC, 255, maximum wait cycles per beat for ack/err; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_icb_cmd_valid  in  1  command valid
- i_icb_cmd_ready  out  1  command ready
- i_icb_cmd_read  in  1  1=read, 0=write
- i_icb_cmd_addr  in  AW  byte address
- i_icb_cmd_wdata  in  ICB_DW  write data
- i_icb_cmd_wmask  in  ICB_DW/8  write byte mask
- i_icb_cmd_size  in  2  log2 bytes for reads (0=1B, 1=2B, 2=4B, 3=8B)
- i_icb_rsp_valid  out  1  response valid
- i_icb_rsp_ready  in  1  response ready
- i_icb_rsp_err  out  1  slave error or timeout
- i_icb_rsp_rdata  out  ICB_DW  read data
- wb_adr  out  AW  beat address
- wb_dat_w  out  WB_DW  beat write data
- wb_sel  out  SW  beat byte select
- wb_we  out  1  write enable
- wb_stb  out  1  strobe
- wb_cyc  out  1  cycle
- wb_dat_r  in  WB_DW  read data
- wb_ack  in  1  acknowledge
- wb_err  in  1  error termination

Behaviour:
- **Clocking and reset:** single clock domain. Reset is synchronous and active-high on rst.
- **Reset values:** state=IDLE; wb_cyc, wb_stb, wb_we, i_icb_rsp_valid, i_icb_rsp_err = 0; wb_adr, wb_dat_w, wb_sel, i_icb_rsp_rdata = 0.
- **Outputs:** all Wishbone and response outputs are registered. i_icb_cmd_ready = (state==IDLE), combinational from state only.
- **States:**
  - IDLE: waiting for a command.
  - BEAT: a Wishbone beat is outstanding.
  - RSP: response pending.
- **Command capture (IDLE):** the handshake in cycle T registers addr, read, wdata and byte mask.
  - Byte mask for writes = wmask.
  - Byte mask for reads = ((1<<(1<<size))-1) << addr[log2(ICB_DW/8)-1:0], truncated to ICB_DW/8 bits.
- **Lane selection:** lane k is active if any of mask bits [k*SW +: SW] is set. Active lanes are issued in ascending k order.
- **No active lanes** (e.g. wmask=0): go IDLE→RSP at T+1, with rsp_err=0 and rdata=0. No Wishbone activity.
- **BEAT presentation:** the first beat is presented at T+1 with wb_cyc=wb_stb=1.
  - wb_adr = {addr[AW-1:log2(ICB_DW/8)], k, log2(SW) zero bits}.
  - wb_sel = mask slice of lane k.
  - wb_dat_w = wdata lane k.
  - wb_we = ~read.
- **Beat termination:** a beat ends in a cycle with wb_ack or wb_err high.
  - On ack, read data for lane k is stored into rdata[k*WB_DW +: WB_DW].
  - If more lanes remain, the next beat is presented in the next cycle; cyc and stb stay high across beats.
  - After the last ack, go to RSP: cyc/stb=0 and rsp_valid=1 in the next cycle.
- **Error:** wb_err (wins over a simultaneous ack) aborts the remaining beats. Go to RSP with rsp_err=1; lanes already read are kept and the rest stay 0.
- **Timeout:** the per-beat counter clears at beat start. If TMO_CYC≠0 and the counter reaches TMO_CYC with no ack/err, drop cyc/stb, abort, and go to RSP with rsp_err=1.
- **Inactive lanes:** rdata for lanes not read is 0. rdata is cleared on every command capture.
- **RSP:** rsp_valid is held with stable rdata/err until i_icb_rsp_ready. The handshake in cycle M returns to IDLE, so cmd_ready=1 at M+1. There is no cmd/rsp overlap: one outstanding transaction at a time.
- **Minimum latency** for a single zero-wait beat (ack in T+1): rsp_valid at T+2.
- **Reset mid-operation:** return to IDLE immediately. The outstanding Wishbone cycle is abandoned (cyc=0); any later ack is ignored in IDLE.
- **Ignored inputs:** wb_ack/wb_err outside BEAT are ignored.

Test Plan:
- **Byte read:** defaults; read addr=0x1000_0003, size=0; slave acks in the same cycle with dat_r=0xA5 → one beat at wb_adr=0x1000_0003, sel=1, we=0; rsp_valid at T+2, rdata=0xA500_0000, err=0.
- **Sparse write split:** write addr=0x2000_0000, wdata=0x1122_3344, wmask=4'b1011 → three beats: adr 0x..00 dat 0x44, adr 0x..01 dat 0x33, adr 0x..03 dat 0x11; cyc held across beats; rsp err=0.
- **WB_DW=16 word read:** slave returns 0xBEEF then 0xDEAD → beats at adr offsets 0 and 2 with sel=2'b11; rdata=0xDEAD_BEEF.
- **Error abort:** 4-byte read, wb_err asserted on beat 2 → no beats 3-4; rsp_err=1; rdata[7:0] = beat-1 data, rdata[31:8]=0.
- **Timeout and backpressure:** TMO_CYC=4, slave never acks → cyc drops after 4 wait cycles and rsp_err=1; with rsp_ready held low for 10 cycles, rsp_valid/rdata/err stay stable and cmd_ready=0.
- **Edge cases:** wmask=0 write → rsp at T+1 with no cyc pulse; rst asserted mid-beat → next cycle cyc=stb=rsp_valid=0 and cmd_ready=1, and a late ack causes no response.
